midi_parser: RTL

Byte-stream parser sitting directly downstream of the UART receiver in the keyboard synthesis chain. It consumes the received byte plus its one-cycle valid strobe, decodes MIDI channel-voice Note On / Note Off messages (including running status), and emits one registered note event per complete message to the tone-generation logic. All other MIDI traffic is discarded without disturbing note decoding.

---
 rtl/midi_parser.sv | 138 +++++++++++++
 1 files changed

// File: rtl/midi_parser.sv
// MIDI Note On/Off byte-stream parser with running status, channel filter and
// inter-byte timeout; emits one registered note event per complete message.
module midi_parser #(
   parameter int unsigned C_CHANNEL      = 0,
   parameter bit          C_OMNI         = 1'b1,
   parameter int unsigned C_TIMEOUT_CLKS = 100_000
) (
   input  logic       i_Clock,
   input  logic       i_Rst_L,
   input  logic       i_RX_DV,
   input  logic [7:0] i_RX_Byte,
   output logic       o_Note_DV,
   output logic       o_Note_On,
   output logic [6:0] o_Note,
   output logic [6:0] o_Velocity,
   output logic [3:0] o_Channel,
   output logic       o_Sync_Err
);

   localparam int unsigned CW = (C_TIMEOUT_CLKS > 0) ? $clog2(C_TIMEOUT_CLKS + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (C_TIMEOUT_CLKS > 0) ? CW'(C_TIMEOUT_CLKS - 1) : '0;
   localparam logic [3:0] CHAN = C_CHANNEL[3:0];

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SKIP    = 2'd1;
   localparam logic [1:0] S_WAIT_D1 = 2'd2;
   localparam logic [1:0] S_WAIT_D2 = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stat_on_q, stat_on_d;
   logic [3:0]    stat_ch_q, stat_ch_d;
   logic [6:0]    note_lat_q, note_lat_d;
   logic          note_dv_q, note_dv_d;
   logic          note_on_q, note_on_d;
   logic [6:0]    note_q, note_d;
   logic [6:0]    vel_q, vel_d;
   logic [3:0]    chan_q, chan_d;
   logic          err_q, err_d;

   logic is_rt, is_note_stat, chan_ok, timeout_hit;

   assign is_rt        = (i_RX_Byte[7:3] == 5'b11111);
   assign is_note_stat = (i_RX_Byte[7:5] == 3'b100);
   assign chan_ok      = C_OMNI || (i_RX_Byte[3:0] == CHAN);
   assign timeout_hit  = (C_TIMEOUT_CLKS != 0) && (state_q == S_WAIT_D2) &&
                         !i_RX_DV && (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      stat_on_d  = stat_on_q;
      stat_ch_d  = stat_ch_q;
      note_lat_d = note_lat_q;
      note_dv_d  = 1'b0;
      err_d      = 1'b0;
      note_on_d  = note_on_q;
      note_d     = note_q;
      vel_d      = vel_q;
      chan_d     = chan_q;

      // Real-time bytes fall through untouched, as if no byte had arrived.
      if (i_RX_DV && !is_rt) begin
         if (i_RX_Byte[7]) begin
            err_d = (state_q == S_WAIT_D2);
            if (is_note_stat && chan_ok) begin
               state_d   = S_WAIT_D1;
               stat_on_d = i_RX_Byte[4];
               stat_ch_d = i_RX_Byte[3:0];
            end else if (i_RX_Byte[7:4] != 4'hF) begin
               state_d = S_SKIP;
            end else begin
               state_d = S_IDLE;
            end
         end else begin
            case (state_q)
               S_WAIT_D1: begin
                  note_lat_d = i_RX_Byte[6:0];
                  state_d    = S_WAIT_D2;
               end
               S_WAIT_D2: begin
                  note_dv_d = 1'b1;
                  note_on_d = stat_on_q && (i_RX_Byte[6:0] != 7'd0);
                  note_d    = note_lat_q;
                  vel_d     = i_RX_Byte[6:0];
                  chan_d    = stat_ch_q;
                  state_d   = S_WAIT_D1;
               end
               default: state_d = state_q;
            endcase
         end
      end else if (timeout_hit) begin
         err_d   = 1'b1;
         state_d = S_WAIT_D1;
      end

      cnt_d = '0;
      if (state_q == S_WAIT_D2 && state_d == S_WAIT_D2) begin
         cnt_d = (C_TIMEOUT_CLKS != 0 && !i_RX_DV) ? cnt_q + CW'(1) : cnt_q;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         note_dv_q <= 1'b0;
         err_q     <= 1'b0;
         note_on_q <= 1'b0;
         note_q    <= '0;
         vel_q     <= '0;
         chan_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         note_dv_q <= note_dv_d;
         err_q     <= err_d;
         note_on_q <= note_on_d;
         note_q    <= note_d;
         vel_q     <= vel_d;
         chan_q    <= chan_d;
      end
   end

   // Status/note latches are only meaningful in WAIT_D1/WAIT_D2, so no reset.
   always_ff @(posedge i_Clock) begin
      stat_on_q  <= stat_on_d;
      stat_ch_q  <= stat_ch_d;
      note_lat_q <= note_lat_d;
   end

   assign o_Note_DV  = note_dv_q;
   assign o_Note_On  = note_on_q;
   assign o_Note     = note_q;
   assign o_Velocity = vel_q;
   assign o_Channel  = chan_q;
   assign o_Sync_Err = err_q;

endmodule
